// File: rtl/wrd_quant_pkg.sv
// Shared quantizer definitions: default stream/shift widths and the run-sequencer state encoding.
package wrd_quant_pkg;

    localparam int unsigned DEF_I_BW     = 32;
    localparam int unsigned DEF_SHIFT_BW = $clog2(DEF_I_BW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/quantizer_shift_table.sv
// Per-layer right-shift register file: one write port, combinational read by layer index.
module quantizer_shift_table
    import wrd_quant_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned SHIFT_BW   = DEF_SHIFT_BW,
    parameter int unsigned LAYER_BW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wr_en,
    input  logic [LAYER_BW-1:0] wr_addr,
    input  logic [SHIFT_BW-1:0] wr_shift,
    input  logic [LAYER_BW-1:0] rd_addr,
    output logic [SHIFT_BW-1:0] rd_shift_c
);

    logic [SHIFT_BW-1:0] tbl [NUM_LAYERS];

    // Entries are compared against the address so out-of-range indices never alias.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(NUM_LAYERS); i++) begin
                tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_LAYERS); i++) begin
                if (wr_en && (wr_addr == LAYER_BW'(i))) begin
                    tbl[i] <= wr_shift;
                end
            end
        end
    end

    always_comb begin
        rd_shift_c = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (rd_addr == LAYER_BW'(i)) begin
                rd_shift_c = tbl[i];
            end
        end
    end

endmodule

// File: rtl/quantizer_ctrl.sv
// Run sequencer for the post-ReLU quantizer: one-stage stream register tagged with per-layer shift.
// Optional beat counter output enabled by defining QUANT_CTRL_BEAT_CNT_EN.
module quantizer_ctrl
    import wrd_quant_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned I_BW       = DEF_I_BW,
    parameter int unsigned SHIFT_BW   = $clog2(I_BW),
    parameter int unsigned LAYER_BW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cfg_wr_en_i,
    input  logic [LAYER_BW-1:0] cfg_addr_i,
    input  logic [SHIFT_BW-1:0] cfg_shift_i,
    output logic                cfg_err_o,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [LAYER_BW-1:0] layer_o,
    input  logic [I_BW-1:0]     data_i,
    input  logic                valid_i,
    input  logic                last_i,
    output logic                ready_o,
    output logic [I_BW-1:0]     data_o,
    output logic                valid_o,
    output logic                last_o,
    input  logic                ready_i,
`ifdef QUANT_CTRL_BEAT_CNT_EN
    output logic [15:0]         beat_cnt_o,
`endif
    output logic [SHIFT_BW-1:0] shift_o
);

    state_t              state_q, state_d;
    logic [LAYER_BW-1:0] layer_q, layer_d;
    logic                done_d;
    logic                accept_c;
    logic                cfg_wr_ok_c;
    logic [SHIFT_BW-1:0] tbl_shift_c;

    assign ready_o     = (state_q == RUN) && (!valid_o || ready_i);
    assign accept_c    = ready_o && valid_i;
    assign cfg_wr_ok_c = cfg_wr_en_i && (state_q == IDLE) && (32'(cfg_addr_i) < NUM_LAYERS);

    quantizer_shift_table #(
        .NUM_LAYERS (NUM_LAYERS),
        .SHIFT_BW   (SHIFT_BW),
        .LAYER_BW   (LAYER_BW)
    ) u_shift_table (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_en      (cfg_wr_ok_c),
        .wr_addr    (cfg_addr_i),
        .wr_shift   (cfg_shift_i),
        .rd_addr    (layer_q),
        .rd_shift_c (tbl_shift_c)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Layer advances on the accepted last beat so the very next beat picks up the new shift.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept_c && last_i) begin
                    if (layer_q == LAYER_BW'(NUM_LAYERS - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        layer_d = layer_q + LAYER_BW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!valid_o || ready_i) begin
                    state_d = IDLE;
                    layer_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                layer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            layer_o   <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            layer_o   <= layer_d;
            done_o    <= done_d;
            busy_o    <= (state_d != IDLE);
            cfg_err_o <= cfg_wr_en_i && !cfg_wr_ok_c;
        end
    end

    // Single output stage: loads on accept, holds under backpressure, empties when consumed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            shift_o <= '0;
        end else if (accept_c) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            last_o  <= last_i;
            shift_o <= tbl_shift_c;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // layer_q mirrors layer_o so the table read is indexed by the registered layer.
    assign layer_q = layer_o;

`ifdef QUANT_CTRL_BEAT_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_cnt_o <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            beat_cnt_o <= '0;
        end else if (accept_c && (beat_cnt_o != 16'hFFFF)) begin
            beat_cnt_o <= beat_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_quantizer_ctrl.sv
// Directed bench for quantizer_ctrl: full runs, stalls, config rejects, 1-beat layers, mid-run reset.
module tb_quantizer_ctrl;

    localparam int unsigned IW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned LW = 2;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          cfg_wr_en_i;
    logic [LW-1:0] cfg_addr_i;
    logic [SW-1:0] cfg_shift_i;
    logic          cfg_err_o;
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] layer_o;
    logic [IW-1:0] data_i;
    logic          valid_i;
    logic          last_i;
    logic          ready_o;
    logic [IW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;
    logic [SW-1:0] shift_o;
`ifdef QUANT_CTRL_BEAT_CNT_EN
    logic [15:0]   beat_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] obs_d[$];
    logic [SW-1:0] obs_s[$];
    logic          obs_l[$];
    int            early_done, stall_viol, err_cnt;
    bit            err_at1, timed_out;
    int            exp_tbl[3];

    always #5 clk = ~clk;

    quantizer_ctrl dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .cfg_wr_en_i (cfg_wr_en_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_shift_i (cfg_shift_i),
        .cfg_err_o   (cfg_err_o),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .layer_o     (layer_o),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .ready_i     (ready_i),
`ifdef QUANT_CTRL_BEAT_CNT_EN
        .beat_cnt_o  (beat_cnt_o),
`endif
        .shift_o     (shift_o)
    );

    task automatic cfg_write(input logic [LW-1:0] addr, input logic [SW-1:0] val, output logic err);
        @(negedge clk);
        cfg_wr_en_i = 1'b1; cfg_addr_i = addr; cfg_shift_i = val;
        @(negedge clk);
        cfg_wr_en_i = 1'b0;
        err = cfg_err_o;
    endtask

    // Starts a run, streams 3 layers of bpl beats and records every consumed output beat.
    task automatic stream_run(input int bpl, input int stall_pct, input bit distinct, input bit mid_cfg);
        int total, src, cyc;
        bit in_acc, prev_stall;
        logic [IW-1:0] pd;
        logic [SW-1:0] ps;
        logic pl;
        total = bpl * 3; src = 0; cyc = 0; prev_stall = 0; pd = '0; ps = '0; pl = 1'b0;
        obs_d.delete(); obs_s.delete(); obs_l.delete();
        early_done = 0; stall_viol = 0; err_cnt = 0; err_at1 = 0; timed_out = 0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        while (obs_d.size() < total && cyc < 2000) begin
            @(negedge clk);
            ready_i     = (stall_pct == 0) || (int'($urandom_range(99)) >= stall_pct);
            cfg_wr_en_i = mid_cfg && (cyc == 0);
            cfg_addr_i  = 2'd1;
            cfg_shift_i = 5'd9;
            valid_i     = (src < total);
            data_i      = distinct ? (32'h100 + 32'(src)) : 32'h100;
            last_i      = (src < total) && ((src % bpl) == bpl - 1);
            #1;
            if (done_o) early_done++;
            if (cfg_err_o) begin
                err_cnt++;
                if (cyc == 1) err_at1 = 1;
            end
            if (prev_stall && (!valid_o || data_o !== pd || shift_o !== ps || last_o !== pl)) stall_viol++;
            if (valid_o && ready_i) begin
                obs_d.push_back(data_o); obs_s.push_back(shift_o); obs_l.push_back(last_o);
            end
            prev_stall = valid_o && !ready_i;
            pd = data_o; ps = shift_o; pl = last_o;
            in_acc = valid_i && ready_o;
            @(posedge clk);
            if (in_acc) src++;
            cyc++;
        end
        #1;
        valid_i = 1'b0; last_i = 1'b0; cfg_wr_en_i = 1'b0; ready_i = 1'b1;
        timed_out = (obs_d.size() < total);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; cfg_wr_en_i = 1'b0; cfg_addr_i = '0; cfg_shift_i = '0;
        start_i = 1'b0; data_i = '0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
        #12;
        checks++; if ({valid_o, last_o, busy_o, done_o, cfg_err_o, ready_o} !== 6'b0) begin errors++;
            $display("FAIL reset_flags: got %b want 000000", {valid_o, last_o, busy_o, done_o, cfg_err_o, ready_o}); end
        checks++; if (data_o !== 32'h0 || shift_o !== 5'd0 || layer_o !== 2'd0) begin errors++;
            $display("FAIL reset_data: data=%h shift=%0d layer=%0d want 0/0/0", data_o, shift_o, layer_o); end
        @(negedge clk); rst_n_i = 1'b1;
    endtask

    task automatic test_basic_run();
        logic err;
        exp_tbl = '{2, 4, 6};
        for (int i = 0; i < 3; i++) begin
            cfg_write(LW'(i), SW'(exp_tbl[i]), err);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_cfg_err%0d: got %b want 0", i, err); end
        end
        stream_run(4, 0, 1'b0, 1'b0);
        checks++; if (timed_out || obs_d.size() != 12) begin errors++;
            $display("FAIL basic_count: got %0d beats want 12", obs_d.size()); end
        for (int i = 0; i < obs_d.size(); i++) begin
            checks++; if (obs_d[i] !== 32'h100 || obs_s[i] !== SW'(exp_tbl[i / 4]) || obs_l[i] !== ((i % 4) == 3)) begin
                errors++; $display("FAIL basic_beat%0d: data=%h shift=%0d last=%b want 100/%0d/%b",
                                   i, obs_d[i], obs_s[i], obs_l[i], exp_tbl[i / 4], (i % 4) == 3); end
        end
        checks++; if (early_done != 0) begin errors++; $display("FAIL basic_early_done: got %0d want 0", early_done); end
        @(negedge clk);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++;
            $display("FAIL basic_done: done=%b busy=%b valid=%b want 1/0/0", done_o, busy_o, valid_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done_o); end
    endtask

    task automatic test_stalls();
        stream_run(4, 50, 1'b1, 1'b0);
        checks++; if (timed_out || obs_d.size() != 12) begin errors++;
            $display("FAIL stall_count: got %0d beats want 12", obs_d.size()); end
        for (int i = 0; i < obs_d.size(); i++) begin
            checks++; if (obs_d[i] !== (32'h100 + 32'(i)) || obs_s[i] !== SW'(exp_tbl[i / 4]) || obs_l[i] !== ((i % 4) == 3)) begin
                errors++; $display("FAIL stall_beat%0d: data=%h shift=%0d last=%b want %h/%0d/%b",
                                   i, obs_d[i], obs_s[i], obs_l[i], 32'h100 + 32'(i), exp_tbl[i / 4], (i % 4) == 3); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol); end
        @(negedge clk);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done_o); end
        @(negedge clk);
    endtask

    task automatic test_cfg_reject();
        logic err;
        stream_run(2, 0, 1'b1, 1'b1);
        checks++; if (err_at1 !== 1'b1 || err_cnt != 1) begin errors++;
            $display("FAIL cfg_run_err: at1=%b count=%0d want 1/1", err_at1, err_cnt); end
        for (int i = 0; i < obs_s.size(); i++) begin
            checks++; if (obs_s[i] !== SW'(exp_tbl[i / 2])) begin errors++;
                $display("FAIL cfg_run_shift%0d: got %0d want %0d", i, obs_s[i], exp_tbl[i / 2]); end
        end
        @(negedge clk); @(negedge clk);
        cfg_write(2'd3, 5'd7, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL cfg_addr3_err: got %b want 1", err); end
        @(negedge clk);
        checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err_o); end
        stream_run(1, 0, 1'b1, 1'b0);
        for (int i = 0; i < obs_s.size(); i++) begin
            checks++; if (obs_s[i] !== SW'(exp_tbl[i])) begin errors++;
                $display("FAIL cfg_tbl%0d: got %0d want %0d", i, obs_s[i], exp_tbl[i]); end
        end
        @(negedge clk); @(negedge clk);
    endtask

    // Start coincides with a write of layer 2 := 5; three 1-beat layers follow without bubbles.
    task automatic test_back_to_back();
        @(negedge clk);
        start_i = 1'b1; cfg_wr_en_i = 1'b1; cfg_addr_i = 2'd2; cfg_shift_i = 5'd5; ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; cfg_wr_en_i = 1'b0;
        valid_i = 1'b1; last_i = 1'b1; data_i = 32'hA0;
        #1;
        checks++; if (cfg_err_o !== 1'b0 || layer_o !== 2'd0 || ready_o !== 1'b1) begin errors++;
            $display("FAIL b2b_start: err=%b layer=%0d ready=%b want 0/0/1", cfg_err_o, layer_o, ready_o); end
        @(negedge clk); data_i = 32'hB1;
        checks++; if (layer_o !== 2'd1 || data_o !== 32'hA0 || shift_o !== 5'd2 || !valid_o || !last_o) begin errors++;
            $display("FAIL b2b_beat0: layer=%0d data=%h shift=%0d want 1/a0/2", layer_o, data_o, shift_o); end
        @(negedge clk); data_i = 32'hC2;
        checks++; if (layer_o !== 2'd2 || data_o !== 32'hB1 || shift_o !== 5'd4) begin errors++;
            $display("FAIL b2b_beat1: layer=%0d data=%h shift=%0d want 2/b1/4", layer_o, data_o, shift_o); end
        @(negedge clk); valid_i = 1'b0; last_i = 1'b0;
        checks++; if (layer_o !== 2'd2 || data_o !== 32'hC2 || shift_o !== 5'd5 || busy_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++; $display("FAIL b2b_beat2: layer=%0d data=%h shift=%0d busy=%b ready=%b want 2/c2/5/1/0",
                               layer_o, data_o, shift_o, busy_o, ready_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || layer_o !== 2'd0 || valid_o !== 1'b0) begin errors++;
            $display("FAIL b2b_done: done=%b busy=%b layer=%0d valid=%b want 1/0/0/0", done_o, busy_o, layer_o, valid_o); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = 32'h200 + 32'(i); last_i = (i == 3);
            @(negedge clk);
        end
        valid_i = 1'b0; last_i = 1'b0;
        checks++; if (layer_o !== 2'd1 || valid_o !== 1'b1 || data_o !== 32'h204 || shift_o !== 5'd4) begin errors++;
            $display("FAIL rst_pre: layer=%0d valid=%b data=%h shift=%0d want 1/1/204/4", layer_o, valid_o, data_o, shift_o); end
        #2 rst_n_i = 1'b0;
        #1;
        checks++; if ({valid_o, last_o, busy_o, done_o, ready_o} !== 5'b0 || data_o !== 32'h0 || shift_o !== 5'd0 || layer_o !== 2'd0) begin
            errors++; $display("FAIL rst_mid: flags=%b data=%h shift=%0d layer=%0d want 0", {valid_o, last_o, busy_o, done_o, ready_o},
                               data_o, shift_o, layer_o); end
        @(negedge clk); rst_n_i = 1'b1;
        stream_run(1, 0, 1'b1, 1'b0);
        checks++; if (timed_out || obs_d.size() != 3) begin errors++; $display("FAIL rst_rerun_count: got %0d want 3", obs_d.size()); end
        for (int i = 0; i < obs_d.size(); i++) begin
            checks++; if (obs_d[i] !== (32'h100 + 32'(i)) || obs_s[i] !== 5'd0) begin errors++;
                $display("FAIL rst_rerun%0d: data=%h shift=%0d want %h/0", i, obs_d[i], obs_s[i], 32'h100 + 32'(i)); end
        end
        @(negedge clk);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rst_rerun_done: got %b want 1", done_o); end
        @(negedge clk);
    endtask

`ifdef QUANT_CTRL_BEAT_CNT_EN
    task automatic test_beat_cnt();
        stream_run(4, 0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        checks++; if (beat_cnt_o !== 16'd12) begin errors++; $display("FAIL cnt_held: got %0d want 12", beat_cnt_o); end
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        checks++; if (beat_cnt_o !== 16'd0) begin errors++; $display("FAIL cnt_clear: got %0d want 0", beat_cnt_o); end
        stream_run(1, 0, 1'b1, 1'b0);
        @(negedge clk); @(negedge clk);
        checks++; if (beat_cnt_o !== 16'd3) begin errors++; $display("FAIL cnt_second: got %0d want 3", beat_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_stalls();
        test_cfg_reject();
        test_back_to_back();
        test_reset_midrun();
`ifdef QUANT_CTRL_BEAT_CNT_EN
        test_beat_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
